rx_mac_frame_filter: RTL and testbench

- Sits directly after the RX MAC top. Consumes its byte stream (GMII_DATA_W = 8) plus the per-byte Ethernet field flags.
- Decides per frame, from the destination MAC, whether to accept or drop:
  - accept if dst equals the station address, or
  - accept if dst is broadcast and broadcast is enabled, or
  - accept everything in promiscuous mode.
- Forwards accepted frames, from the first dst MAC byte through the last FCS byte, with SOF/EOF/error framing. Captures EtherType and keeps accept/drop statistics.

---
 rtl/rx_mac_frame_filter.sv | 205 ++++++++++++++++++++
 tb/tb_rx_mac_frame_filter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_mac_frame_filter.sv
// Destination-MAC frame filter behind the RX MAC: forwards accepted frames with SOF/EOF/err, keeps stats.
// Latency: fixed 6 cycles input byte to output byte (delay line spans the dst MAC decision window).
// Backpressure: none; the MAC stream cannot be stalled, so output beats appear exactly as input arrived.
module rx_mac_frame_filter #(
   parameter int CNT_W = 16,
   parameter int DLY   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data_i,
   input  logic             rx_data_valid_i,
   input  logic             is_dst_mac_i,
   input  logic             is_src_mac_i,
   input  logic             is_ether_type_i,
   input  logic             is_payload_or_fcs_i,
   input  logic             invalid_frame_i,
   input  logic [47:0]      station_mac_i,
   input  logic             promisc_en_i,
   input  logic             bcast_en_i,
   output logic [7:0]       out_data_o,
   output logic             out_valid_o,
   output logic             out_sof_o,
   output logic             out_eof_o,
   output logic             out_err_o,
   output logic [15:0]      ether_type_o,
   output logic [CNT_W-1:0] accept_cnt_o,
   output logic [CNT_W-1:0] drop_cnt_o,
   output logic [CNT_W-1:0] runt_cnt_o
);

   // The pass decision lands exactly when dst byte 0 reaches the last stage only for a 6-deep line.
   if (DLY != 6) begin : g_dly_chk
      $error("rx_mac_frame_filter: DLY must equal the dst MAC length (6)");
   end

   typedef enum logic [1:0] {IDLE, DST, HDR, PAYLOAD} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Delay line: data, valid and payload/FCS flag per stage; index DLY-1 is the output stage.
   logic [7:0]     dly_dat [DLY];
   logic [DLY-1:0] dly_vld;
   logic [DLY-1:0] dly_pay;

   state_t      state;
   logic [2:0]  idx;          // dst byte index of the byte currently on rx_data_i
   logic        match_uc;     // all dst bytes so far equal the station address
   logic        match_bc;     // all dst bytes so far equal 8'hFF
   logic        frame_err;    // decide-side sticky error for the frame being received
   logic [15:0] et_shadow;
   logic        et_lo_next;   // next EtherType byte goes to the low half

   // Output-side per-frame state, loaded at decision time and held until EOF drains.
   logic        out_act;      // a decided frame occupies the output side
   logic        out_pass;
   logic        out_first;
   logic        out_err_r;

   logic [2:0]  cmp_idx;
   logic [7:0]  stn_byte;
   logic        byte_uc;
   logic        byte_bc;
   logic        pass_now;
   logic        eof_raw;

   // Station address byte for the current dst index; byte 0 is compared while still in IDLE.
   always_comb begin
      stn_byte = 8'h00;
      cmp_idx  = (state == IDLE) ? 3'd0 : idx;
      case (cmp_idx)
         3'd0:    stn_byte = station_mac_i[47:40];
         3'd1:    stn_byte = station_mac_i[39:32];
         3'd2:    stn_byte = station_mac_i[31:24];
         3'd3:    stn_byte = station_mac_i[23:16];
         3'd4:    stn_byte = station_mac_i[15:8];
         3'd5:    stn_byte = station_mac_i[7:0];
         default: stn_byte = 8'h00;
      endcase
   end

   assign byte_uc  = (rx_data_i == stn_byte);
   assign byte_bc  = (rx_data_i == 8'hFF);
   assign pass_now = promisc_en_i | (match_uc & byte_uc) | (bcast_en_i & match_bc & byte_bc);

   // Frame end as seen at the output stage, whether or not the frame is forwarded.
   assign eof_raw = out_act & dly_vld[DLY-1] & ~dly_vld[DLY-2];

   assign out_valid_o = dly_vld[DLY-1] & out_pass;
   assign out_data_o  = out_valid_o ? dly_dat[DLY-1] : 8'h00;
   assign out_sof_o   = out_valid_o & out_first;
   assign out_eof_o   = out_valid_o & ~dly_vld[DLY-2];
   // A frame whose last byte never reached payload/FCS was truncated in the header.
   assign out_err_o   = out_eof_o & (out_err_r | ~dly_pay[DLY-1]);

   // Shift the byte stream through the fixed-length delay line every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DLY; i++) dly_dat[i] <= 8'h00;
         dly_vld <= '0;
         dly_pay <= '0;
      end else begin
         dly_dat[0] <= rx_data_i;
         for (int i = 1; i < DLY; i++) dly_dat[i] <= dly_dat[i-1];
         dly_vld <= {dly_vld[DLY-2:0], rx_data_valid_i};
         dly_pay <= {dly_pay[DLY-2:0], is_payload_or_fcs_i};
      end
   end

   // Frame FSM: dst address decision, header capture, error tracking, output framing and statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= 3'd0;
         match_uc     <= 1'b0;
         match_bc     <= 1'b0;
         frame_err    <= 1'b0;
         et_shadow    <= 16'h0000;
         et_lo_next   <= 1'b0;
         out_act      <= 1'b0;
         out_pass     <= 1'b0;
         out_first    <= 1'b0;
         out_err_r    <= 1'b0;
         ether_type_o <= 16'h0000;
         accept_cnt_o <= '0;
         drop_cnt_o   <= '0;
         runt_cnt_o   <= '0;
      end else begin
         out_first <= 1'b0;

         // Retire the draining frame; a new decision below cannot coincide with this.
         if (eof_raw) begin
            out_act  <= 1'b0;
            out_pass <= 1'b0;
            if (out_pass) begin
               if (accept_cnt_o != CNT_MAX) accept_cnt_o <= accept_cnt_o + CNT_ONE;
               ether_type_o <= et_shadow;
            end else begin
               if (drop_cnt_o != CNT_MAX) drop_cnt_o <= drop_cnt_o + CNT_ONE;
            end
         end

         case (state)
            IDLE: begin
               if (rx_data_valid_i && is_dst_mac_i) begin
                  idx       <= 3'd1;
                  match_uc  <= byte_uc;
                  match_bc  <= byte_bc;
                  frame_err <= invalid_frame_i;
                  out_err_r <= 1'b0;
                  state     <= DST;
               end
            end
            DST: begin
               if (!rx_data_valid_i) begin
                  if (runt_cnt_o != CNT_MAX) runt_cnt_o <= runt_cnt_o + CNT_ONE;
                  out_pass <= 1'b0;
                  state    <= IDLE;
               end else begin
                  frame_err <= frame_err | invalid_frame_i;
                  if (idx == 3'd5) begin
                     out_pass   <= pass_now;
                     out_act    <= 1'b1;
                     out_first  <= 1'b1;
                     et_lo_next <= 1'b0;
                     state      <= HDR;
                  end else begin
                     idx      <= idx + 3'd1;
                     match_uc <= match_uc & byte_uc;
                     match_bc <= match_bc & byte_bc;
                  end
               end
            end
            HDR: begin
               if (!rx_data_valid_i) begin
                  out_err_r <= 1'b1;
                  state     <= IDLE;
               end else begin
                  frame_err <= frame_err | invalid_frame_i;
                  if (is_src_mac_i) et_lo_next <= 1'b0;
                  if (is_ether_type_i) begin
                     if (et_lo_next) begin
                        et_shadow[7:0] <= rx_data_i;
                     end else begin
                        et_shadow[15:8] <= rx_data_i;
                        et_lo_next      <= 1'b1;
                     end
                  end
                  if (is_payload_or_fcs_i) state <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (!rx_data_valid_i) begin
                  out_err_r <= frame_err | invalid_frame_i;
                  state     <= IDLE;
               end else begin
                  frame_err <= frame_err | invalid_frame_i;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_mac_frame_filter.sv
module tb_rx_mac_frame_filter;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data_i;
   logic        rx_data_valid_i;
   logic        is_dst_mac_i;
   logic        is_src_mac_i;
   logic        is_ether_type_i;
   logic        is_payload_or_fcs_i;
   logic        invalid_frame_i;
   logic [47:0] station_mac_i;
   logic        promisc_en_i;
   logic        bcast_en_i;
   logic [7:0]  out_data_o;
   logic        out_valid_o;
   logic        out_sof_o;
   logic        out_eof_o;
   logic        out_err_o;
   logic [15:0] ether_type_o;
   logic [15:0] accept_cnt_o;
   logic [15:0] drop_cnt_o;
   logic [15:0] runt_cnt_o;

   rx_mac_frame_filter #(.CNT_W(16), .DLY(6)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .rx_data_i           (rx_data_i),
      .rx_data_valid_i     (rx_data_valid_i),
      .is_dst_mac_i        (is_dst_mac_i),
      .is_src_mac_i        (is_src_mac_i),
      .is_ether_type_i     (is_ether_type_i),
      .is_payload_or_fcs_i (is_payload_or_fcs_i),
      .invalid_frame_i     (invalid_frame_i),
      .station_mac_i       (station_mac_i),
      .promisc_en_i        (promisc_en_i),
      .bcast_en_i          (bcast_en_i),
      .out_data_o          (out_data_o),
      .out_valid_o         (out_valid_o),
      .out_sof_o           (out_sof_o),
      .out_eof_o           (out_eof_o),
      .out_err_o           (out_err_o),
      .ether_type_o        (ether_type_o),
      .accept_cnt_o        (accept_cnt_o),
      .drop_cnt_o          (drop_cnt_o),
      .runt_cnt_o          (runt_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  d;
      logic        sof;
      logic        eof;
      logic        err;
      logic [31:0] cyc;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b1;

   localparam logic [47:0] STN   = 48'h02_00_00_00_00_01;
   localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every output beat must match the head of the expected queue, including its cycle.
   always @(negedge clk) begin
      beat_t e;
      if (mon_en && !rst) begin
         if (out_valid_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: data=%h sof=%b eof=%b cyc=%0d, expected no output",
                        out_data_o, out_sof_o, out_eof_o, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("beat{d,sof,eof,err,cyc}",
                   64'({out_data_o, out_sof_o, out_eof_o, out_err_o, cyc}), 64'(e));
            end
         end else if (out_sof_o || out_eof_o || out_err_o) begin
            checks++;
            errors++;
            $display("FAIL framing_without_valid: sof=%b eof=%b err=%b, expected all 0",
                     out_sof_o, out_eof_o, out_err_o);
         end
      end
   end

   task automatic idle_inputs();
      rx_data_i           = 8'h00;
      rx_data_valid_i     = 1'b0;
      is_dst_mac_i        = 1'b0;
      is_src_mac_i        = 1'b0;
      is_ether_type_i     = 1'b0;
      is_payload_or_fcs_i = 1'b0;
      invalid_frame_i     = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int g = 0; g < n; g++) begin
         @(posedge clk); #1;
         idle_inputs();
      end
   endtask

   // One frame: 6 dst, 6 src, 2 EtherType, rest payload+FCS; then the 20-byte minimum gap.
   task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                             input int inv_at, input int rst_at, input bit exp_pass);
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         if (rst_at >= 0 && i == rst_at + 1) rst = 1'b0;
         if (i < 6)       b = dst[47-8*i -: 8];
         else if (i < 12) b = 8'hA0 + 8'(i);
         else if (i == 12) b = et[15:8];
         else if (i == 13) b = et[7:0];
         else             b = 8'(i * 7 + 3);
         rx_data_i           = b;
         rx_data_valid_i     = 1'b1;
         is_dst_mac_i        = (i < 6);
         is_src_mac_i        = (i >= 6 && i < 12);
         is_ether_type_i     = (i == 12 || i == 13);
         is_payload_or_fcs_i = (i >= 14);
         invalid_frame_i     = (i == inv_at);
         if (exp_pass)
            exp_q.push_back('{d: b, sof: (i == 0), eof: (i == len - 1),
                              err: (i == len - 1) && (inv_at >= 0), cyc: cyc + 6});
         if (i == rst_at) begin
            chk("valid_before_reset", 64'(out_valid_o), 64'(1));
            rst = 1'b1;
            #1;
            chk("rst_valid", 64'(out_valid_o), 64'(0));
            chk("rst_data", 64'(out_data_o), 64'(0));
            chk("rst_sof_eof_err", 64'({out_sof_o, out_eof_o, out_err_o}), 64'(0));
            chk("rst_accept_cnt", 64'(accept_cnt_o), 64'(0));
            chk("rst_ether_type", 64'(ether_type_o), 64'(0));
         end
      end
      gap(20);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      station_mac_i = STN;
      promisc_en_i  = 1'b0;
      bcast_en_i    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({out_data_o, out_valid_o, out_sof_o, out_eof_o, out_err_o}), 64'(0));
      chk("reset_ether_type", 64'(ether_type_o), 64'(0));
      chk("reset_counters", 64'({accept_cnt_o, drop_cnt_o, runt_cnt_o}), 64'(0));
      rst = 1'b0;
      gap(4);

      // Unicast match
      send_frame(STN, 16'h0800, 64, -1, -1, 1'b1);
      chk("ucast_accept_cnt", 64'(accept_cnt_o), 64'(1));
      chk("ucast_ether_type", 64'(ether_type_o), 64'h0800);
      chk("ucast_drop_cnt", 64'(drop_cnt_o), 64'(0));

      // Address mismatch
      send_frame(OTHER, 16'h0800, 64, -1, -1, 1'b0);
      chk("mismatch_drop_cnt", 64'(drop_cnt_o), 64'(1));
      chk("mismatch_accept_cnt", 64'(accept_cnt_o), 64'(1));

      // Promiscuous
      promisc_en_i = 1'b1;
      send_frame(OTHER, 16'h86DD, 64, -1, -1, 1'b1);
      promisc_en_i = 1'b0;
      chk("promisc_accept_cnt", 64'(accept_cnt_o), 64'(2));
      chk("promisc_ether_type", 64'(ether_type_o), 64'h86DD);

      // Broadcast disabled then enabled
      send_frame(BCAST, 16'h0806, 64, -1, -1, 1'b0);
      chk("bcast_off_drop_cnt", 64'(drop_cnt_o), 64'(2));
      chk("bcast_off_ether_type", 64'(ether_type_o), 64'h86DD);
      bcast_en_i = 1'b1;
      send_frame(BCAST, 16'h0806, 64, -1, -1, 1'b1);
      bcast_en_i = 1'b0;
      chk("bcast_on_accept_cnt", 64'(accept_cnt_o), 64'(3));
      chk("bcast_on_ether_type", 64'(ether_type_o), 64'h0806);

      // Runt: three dst bytes then valid drops
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         rx_data_i       = STN[47-8*i -: 8];
         rx_data_valid_i = 1'b1;
         is_dst_mac_i    = 1'b1;
      end
      gap(20);
      chk("runt_cnt", 64'(runt_cnt_o), 64'(1));
      chk("runt_accept_drop", 64'({accept_cnt_o, drop_cnt_o}), 64'({16'd3, 16'd2}));

      // Error pulsed in payload of a matched frame
      send_frame(STN, 16'h0800, 64, 30, -1, 1'b1);
      chk("err_accept_cnt", 64'(accept_cnt_o), 64'(4));

      // Back-to-back with minimum gap
      send_frame(STN, 16'h0800, 64, -1, -1, 1'b1);
      send_frame(STN, 16'h88CC, 60, -1, -1, 1'b1);
      chk("b2b_accept_cnt", 64'(accept_cnt_o), 64'(6));
      chk("b2b_ether_type", 64'(ether_type_o), 64'h88CC);

      // Reset mid-payload: output stops at once, remainder ignored
      mon_en = 1'b0;
      send_frame(STN, 16'h0800, 64, -1, 40, 1'b0);
      mon_en = 1'b1;
      gap(10);
      chk("post_rst_counters", 64'({accept_cnt_o, drop_cnt_o, runt_cnt_o}), 64'(0));

      // Recovery frame after reset
      send_frame(STN, 16'h0800, 64, -1, -1, 1'b1);
      chk("recover_accept_cnt", 64'(accept_cnt_o), 64'(1));
      chk("recover_ether_type", 64'(ether_type_o), 64'h0800);

      gap(5);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
